// File: rtl/divider_scheduler_if.sv
// divider_scheduler_if: bundle between the requesters / shared clock_divider
// and divider_scheduler.
//   req        per-requester level request
//   period     packed divider max per requester, slice i = period[7*i+:7]
//   ticks      packed tick count per requester, slice i = ticks[TW*i+:TW]
//   div_at_max at_max from the shared divider
//   div_enable / div_clear / div_max   control to the shared divider
//   grant      one-hot current owner
//   done       one-cycle completion pulse to the owner
//   busy       scheduler not idle
// slave = scheduler side, master = requester/divider side.
interface divider_scheduler_if #(
  parameter int NREQ = 4,
  parameter int TW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*7-1:0]  period;
  logic [NREQ*TW-1:0] ticks;
  logic               div_at_max;
  logic               div_enable;
  logic               div_clear;
  logic [6:0]         div_max;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport slave (
    input  req, period, ticks, div_at_max,
    output div_enable, div_clear, div_max, grant, done, busy
  );

  modport master (
    output req, period, ticks, div_at_max,
    input  div_enable, div_clear, div_max, grant, done, busy
  );
endinterface

// File: rtl/divider_scheduler.sv
// divider_scheduler: arbitrates NREQ requesters onto one shared clock_divider.
// The winner's period/ticks are latched at grant; the divider is cleared for
// one cycle (LOAD), enabled for ticks*(period+1) cycles (RUN), then cleared
// again while done pulses to the owner (DONE). Dropping req[owner] during
// LOAD/RUN aborts through the same cleanup cycle without a done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  divider_scheduler_if.slave (req/period/ticks/div_at_max in,
//        div_enable/div_clear/div_max/grant/done/busy out)
// Configuration:
//   DIVSCHED_ROUND_ROBIN_EN  defined   -> round-robin from pointer+1
//                            undefined -> fixed priority, lowest index wins
module divider_scheduler #(
  parameter int NREQ = 4,
  parameter int TW   = 4
) (
  input logic               clk,
  input logic               rst,
  divider_scheduler_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [IW-1:0]   owner_q;
  logic [6:0]      per_q;
  logic [TW-1:0]   rem_q;
  logic            rst_hold_q;   // keeps div_clear high across reset cycles

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [TW-1:0]   win_ticks;

`ifdef DIVSCHED_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  // Search upward from ptr+1 with wrap; walking k downward lets the nearest
  // candidate overwrite farther ones.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= IW'(NREQ - 1);
    else if (state_q == S_IDLE && win_vld)
      ptr_q <= win_idx;
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`endif

  assign win_ticks = bus.ticks[TW*win_idx +: TW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      per_q      <= '0;
      rem_q      <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      rst_hold_q <= 1'b0;
      done_q     <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            owner_q <= win_idx;
            grant_q <= NREQ'(1) << win_idx;
            per_q   <= bus.period[7*win_idx +: 7];
            // zero ticks still runs one divider period
            rem_q   <= (win_ticks == '0) ? TW'(1) : win_ticks;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!bus.req[owner_q]) begin
            grant_q <= '0;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // withdrawal wins over a coincident final at_max: no done pulse
          if (!bus.req[owner_q]) begin
            grant_q <= '0;
            state_q <= S_DONE;
          end else if (bus.div_at_max) begin
            if (rem_q == TW'(1)) begin
              done_q  <= grant_q;
              grant_q <= '0;
              state_q <= S_DONE;
            end else begin
              rem_q <= rem_q - TW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;   // S_DONE: one cleanup cycle
      endcase
    end
  end

  assign bus.div_enable = (state_q == S_RUN);
  assign bus.div_clear  = rst_hold_q || (state_q == S_LOAD) || (state_q == S_DONE);
  assign bus.div_max    = per_q;
  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule
